rk4_result_uart: RTL and testbench

Downstream stage of `RK4_fpga`. Captures each (X, Y) Q16.16 result pair as it is produced, buffers the pairs in a small FIFO and serialises them over an 8N1 UART line so the host can log the trajectory. The solver is never stalled: results arriving while the buffer is full are dropped and flagged.

---
 rtl/rk4_result_uart.sv | 192 +++++++++++++++++++
 tb/tb_rk4_result_uart.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rk4_result_uart.sv
// rk4_result_uart
// ---------------
// Downstream of the RK4 solver: captures each (X, Y) Q16.16 result pair into a
// small FIFO and streams it to the host over an 8N1 UART line. Every entry goes
// out as 8 frames, X[31:24] first and Y[7:0] last, each frame LSB first. The
// solver is never back-pressured; a result that finds the FIFO full (with no pop
// in the same cycle) is dropped and the sticky overflow flag is raised.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_x_in      X result, Q16.16
//   i_y_in      Y result, Q16.16
//   i_valid     one-cycle strobe qualifying i_x_in / i_y_in
//   o_tx        UART serial output, idle high, registered
//   o_busy      frame in flight or FIFO non-empty
//   o_overflow  sticky drop flag, cleared only by reset
//   o_count     FIFO occupancy (0 .. FIFO_DEPTH)

`timescale 1ns/1ps

module rk4_result_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [31:0]                   i_x_in,
    input  logic [31:0]                   i_y_in,
    input  logic                          i_valid,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_tx;
    logic [63:0]     r_shift;
    logic [7:0]      r_byte;
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_byte_idx;
    logic [BW-1:0]   r_baud;

    logic            w_pop;
    logic            w_push;
    logic            w_baud_done;

    // The head is popped on the IDLE->LOAD edge, so count drops one cycle after
    // the push and a full FIFO can still accept a result on that same edge.
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_push      = i_valid && ((r_count != FULL_COUNT) || w_pop);
    assign w_baud_done = (r_baud == BAUD_LAST);

    // FIFO bookkeeping. Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (i_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; stale words are never read because count gates pops.
    // When full with a simultaneous pop, the write lands in the slot being read,
    // which the pop has already captured.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_x_in, i_y_in};
        end
    end

    // Transmitter. r_shift holds the bytes still to send (next one in [63:56]);
    // r_byte is the frame in progress, shifted right so bit 0 is always next.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_byte     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_baud     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_byte_idx <= '0;
                    r_byte     <= r_shift[63:56];
                    r_shift    <= {r_shift[55:0], 8'h00};
                    r_baud     <= '0;
                    r_tx       <= 1'b0;
                    r_state    <= S_START;
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_tx      <= r_byte[0];
                        r_byte    <= {1'b0, r_byte[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_byte[0];
                            r_byte    <= {1'b0, r_byte[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_byte_idx != 3'd7) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_byte     <= r_shift[63:56];
                            r_shift    <= {r_shift[55:0], 8'h00};
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = (r_state != S_IDLE) || (r_count != '0);
    assign o_overflow = r_overflow;
    assign o_count    = r_count;

endmodule

// File: tb/tb_rk4_result_uart.sv
// Testbench for rk4_result_uart.
// A timeline model (FIFO queue plus the line schedule of the entry being sent)
// predicts tx, busy, count and overflow after every clock edge; a compare process
// checks them on each falling edge. Directed tests add literal expectations for
// latency, decoded bytes, entry duration, overflow behaviour, reset mid-frame and
// baud spacing at CLKS_PER_BIT = 868 on a second instance.

`timescale 1ns/1ps

module tb_rk4_result_uart;

    localparam int CPB          = 4;
    localparam int DEPTH        = 8;
    localparam int CPB_B        = 868;
    localparam int ENTRY_CYCLES = 80 * CPB;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [31:0] xIn     = '0;
    logic [31:0] yIn     = '0;
    logic        validIn = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [3:0]  count;

    logic        rstB    = 1'b1;
    logic [31:0] xB      = '0;
    logic [31:0] yB      = '0;
    logic        validB  = 1'b0;
    logic        txB;
    logic        busyB;
    logic        overflowB;
    logic [3:0]  countB;

    int checks = 0;
    int errors = 0;
    logic checkEnable = 1'b0;

    always #5 clk = ~clk;

    rk4_result_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_x_in     (xIn),
        .i_y_in     (yIn),
        .i_valid    (validIn),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_overflow (overflow),
        .o_count    (count)
    );

    rk4_result_uart #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dutBaud (
        .i_clk      (clk),
        .i_rst      (rstB),
        .i_x_in     (xB),
        .i_y_in     (yB),
        .i_valid    (validB),
        .o_tx       (txB),
        .o_busy     (busyB),
        .o_overflow (overflowB),
        .o_count    (countB)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: mq holds accepted entries, mCur is the one on the line.
    // An entry popped at edge p drives frames after edges p+1 .. p+80*CPB, the
    // transmitter is back in IDLE after edge p+1+80*CPB and may pop one edge later.
    logic [63:0] mq[$];
    logic [63:0] mCur     = '0;
    int          mEdge    = 0;
    int          mLoad    = -10;
    int          mTxStart = -10;
    int          mTxEnd   = -1;
    logic        mOvf     = 1'b0;

    always @(posedge clk) begin : modelProc
        bit doPop;
        bit doPush;
        mEdge++;
        if (rst) begin
            mq.delete();
            mOvf     = 1'b0;
            mLoad    = -10;
            mTxStart = -10;
            mTxEnd   = -1;
        end else begin
            doPop  = (mq.size() > 0) && (mEdge >= mTxEnd + 1);
            doPush = validIn && ((mq.size() < DEPTH) || doPop);
            if (validIn && !doPush) mOvf = 1'b1;
            if (doPop) begin
                mCur     = mq.pop_front();
                mLoad    = mEdge;
                mTxStart = mEdge + 1;
                mTxEnd   = mEdge + 1 + ENTRY_CYCLES;
            end
            if (doPush) mq.push_back({xIn, yIn});
        end
    end

    always @(negedge clk) begin : compareProc
        logic       expTx;
        logic       expBusy;
        logic [7:0] bv;
        int         k;
        int         f;
        int         b;
        if (checkEnable) begin
            if (rst) begin
                checkOutput("resetTx", {63'b0, tx}, 64'd1);
                checkOutput("resetBusy", {63'b0, busy}, 64'd0);
                checkOutput("resetCount", {60'b0, count}, 64'd0);
                checkOutput("resetOverflow", {63'b0, overflow}, 64'd0);
            end else begin
                expTx = 1'b1;
                if (mEdge >= mTxStart && mEdge < mTxEnd) begin
                    k  = mEdge - mTxStart;
                    f  = k / (10 * CPB);
                    b  = (k % (10 * CPB)) / CPB;
                    bv = mCur[63 - 8 * f -: 8];
                    if (b == 0) expTx = 1'b0;
                    else if (b < 9) expTx = bv[b - 1];
                end
                expBusy = ((mEdge >= mLoad) && (mEdge < mTxEnd)) || (mq.size() != 0);
                checkOutput("lineTx", {63'b0, tx}, {63'b0, expTx});
                checkOutput("busy", {63'b0, busy}, {63'b0, expBusy});
                checkOutput("count", {60'b0, count}, 64'(mq.size()));
                checkOutput("overflow", {63'b0, overflow}, {63'b0, mOvf});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid pulse, sampled at the next rising edge.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        xIn     = x;
        yIn     = y;
        validIn = 1'b1;
        tick();
        validIn = 1'b0;
    endtask

    task automatic idleUntil(input int e);
        while (mEdge < e - 1) tick();
    endtask

    task automatic waitIdle(input string name, input int budget);
        int   n = 0;
        logic timedOut;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        timedOut = (busy !== 1'b0);
        checkOutput(name, {63'b0, timedOut}, 64'd0);
    endtask

    // Decode one 8-frame entry by sampling mid-bit. startEdge is the edge after
    // which the first start bit was seen.
    task automatic receiveEntry(output logic [63:0] data, output int startEdge);
        int   n = 0;
        logic timedOut;
        data      = '0;
        startEdge = -1;
        while (tx !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        timedOut = (tx !== 1'b0);
        if (timedOut) begin
            checkOutput("rxStartTimeout", {63'b0, timedOut}, 64'd0);
            return;
        end
        startEdge = mEdge;
        for (int f = 0; f < 8; f++) begin
            logic [7:0] bv;
            if (f == 0) repeat (CPB / 2) tick();
            else repeat (CPB) tick();
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) tick();
                bv[j] = tx;
            end
            repeat (CPB) tick();
            data = {data[55:0], bv};
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainProc
        logic [63:0] rxData;
        int          rxStart;
        int          pushEdge;
        int          n;
        int          transEdge [10];
        logic        prev;
        logic        timedOut;

        // Reset state
        tick();
        checkEnable = 1'b1;
        checkOutput("rstTxLit", {63'b0, tx}, 64'd1);
        checkOutput("rstBusyLit", {63'b0, busy}, 64'd0);
        checkOutput("rstCountLit", {60'b0, count}, 64'd0);
        checkOutput("rstOverflowLit", {63'b0, overflow}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single result
        $display("[TB] single result");
        applyStimulus(32'h0001_8000, 32'h0002_0000);
        pushEdge = mEdge;
        checkOutput("singleCountAfterPush", {60'b0, count}, 64'd1);
        receiveEntry(rxData, rxStart);
        checkOutput("singleLatency", 64'(rxStart - pushEdge), 64'd2);
        checkOutput("singleBytes", rxData, 64'h0001_8000_0002_0000);
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("singleDuration", 64'(mEdge - rxStart), 64'd320);
        repeat (5) tick();

        // Full FIFO with a result arriving on the pop edge
        $display("[TB] full with simultaneous pop");
        applyStimulus(32'hA000_0000, 32'hB000_0000);
        pushEdge = mEdge;
        for (int i = 1; i <= 8; i++) applyStimulus(32'hA000_0000 + i, 32'hB000_0000 + i);
        checkOutput("fullCount", {60'b0, count}, 64'd8);
        idleUntil(pushEdge + 323);
        applyStimulus(32'hCAFE_0001, 32'hF00D_0002);
        checkOutput("fullPopCount", {60'b0, count}, 64'd8);
        checkOutput("fullPopOverflow", {63'b0, overflow}, 64'd0);
        waitIdle("fullPopDrain", 3000);

        // Overflow: ten consecutive pulses
        $display("[TB] overflow");
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h1000_0000 + i, 32'h2000_0000 + i);
            if (i == 8) begin
                checkOutput("ovfCount9", {60'b0, count}, 64'd8);
                checkOutput("ovfFlag9", {63'b0, overflow}, 64'd0);
            end
            if (i == 9) begin
                checkOutput("ovfCount10", {60'b0, count}, 64'd8);
                checkOutput("ovfFlag10", {63'b0, overflow}, 64'd1);
            end
        end
        waitIdle("ovfDrain", 3000);
        checkOutput("ovfSticky", {63'b0, overflow}, 64'd1);

        // Reset during DATA bit 3 of byte 2
        $display("[TB] reset mid-byte");
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        applyStimulus(32'hA5C3_00F0, 32'h1122_3344);
        pushEdge = mEdge;
        applyStimulus(32'h7777_7777, 32'h8888_8888);
        while (mEdge < pushEdge + 2 + 97) tick();
        checkOutput("preResetTx", {63'b0, tx}, 64'd0);
        checkOutput("preResetCount", {60'b0, count}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetTx", {63'b0, tx}, 64'd1);
        checkOutput("midResetCount", {60'b0, count}, 64'd0);
        checkOutput("midResetBusy", {63'b0, busy}, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D);
        receiveEntry(rxData, rxStart);
        checkOutput("postResetBytes", rxData, 64'hDEAD_BEEF_0BAD_F00D);
        waitIdle("postResetDrain", 100);

        // Baud accuracy at 868 clocks per bit
        $display("[TB] baud accuracy");
        rstB = 1'b0;
        tick();
        xB     = 32'h5555_5555;
        yB     = 32'h0;
        validB = 1'b1;
        tick();
        validB   = 1'b0;
        pushEdge = mEdge;
        prev     = txB;
        timedOut = 1'b0;
        for (int t = 0; t < 10 && !timedOut; t++) begin
            n = 0;
            while (txB === prev && n < 2000) begin
                tick();
                n++;
            end
            if (txB === prev) timedOut = 1'b1;
            transEdge[t] = mEdge;
            prev = txB;
        end
        checkOutput("baudTimeout", {63'b0, timedOut}, 64'd0);
        if (!timedOut) begin
            checkOutput("baudLatency", 64'(transEdge[0] - pushEdge), 64'd2);
            for (int t = 1; t < 10; t++) begin
                checkOutput("baudSpacing", 64'(transEdge[t] - transEdge[t - 1]), 64'd868);
            end
        end
        rstB = 1'b1;
        repeat (2) tick();

        checkEnable = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
